// File: rtl/conv_pkg.sv
// Shared definitions for the Laplacian result collector: frame FSM state
// encoding, FIFO entry width and the sum-to-pixel rectifier.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // FIFO entry layout: {eof, eol, pixel[7:0]}
  localparam int ENTRY_W = 10;

  // Negative sums clamp to black; non-negative sums (0..31) scale by 8,
  // so the brightest pixel is 248.
  function automatic logic [7:0] rectify(input logic signed [5:0] s);
    return s[5] ? 8'd0 : {s[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/laplacian_result_collector_if.sv
// Sample-in / pixel-out stream bundle of the result collector.
//   sum_in/sum_done : adder-tree sample and its strobe
//   pix_*           : show-ahead pixel stream with valid/ready handshake
// slave  : the collector side
// master : the environment (adder tree + downstream consumer)
interface laplacian_result_collector_if;
  logic signed [5:0] sum_in;
  logic              sum_done;
  logic [7:0]        pix_out;
  logic              pix_eol;
  logic              pix_eof;
  logic              pix_valid;
  logic              pix_ready;

  modport slave (
    input  sum_in, sum_done, pix_ready,
    output pix_out, pix_eol, pix_eof, pix_valid
  );

  modport master (
    output sum_in, sum_done, pix_ready,
    input  pix_out, pix_eol, pix_eof, pix_valid
  );
endinterface

// File: rtl/result_fifo.sv
// Show-ahead synchronous FIFO. dout presents the head entry whenever the
// FIFO is non-empty (zero otherwise). A push while full is accepted only if
// a pop happens in the same cycle; a pop while empty is ignored.
//   clk, rst_n  : clock, async active-low reset
//   push, din   : write strobe and data
//   pop         : consume the head
//   dout        : head entry
//   full, empty : occupancy flags
module result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/laplacian_result_collector.sv
// Collects adder-tree sums for one frame, rectifies them to 8-bit pixels,
// tags raster eol/eof and streams them out through a show-ahead FIFO.
//   clk, rst_n  : clock, async active-low reset
//   start       : arms one frame (IDLE only); clears overflow and counters
//   busy        : frame in RUN or FLUSH
//   frame_done  : one-cycle pulse while in DONE
//   overflow    : sticky, a sample was dropped on a full FIFO
//   stream      : sample input and pixel output stream
module laplacian_result_collector
  import conv_pkg::*;
#(
  parameter int OUT_W = 26,
  parameter int OUT_H = 26,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic frame_done,
  output logic overflow,
  laplacian_result_collector_if.slave stream
);
  localparam logic [7:0] COL_LAST = 8'(OUT_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(OUT_H - 1);

  state_e             state_q, state_d;
  logic [7:0]         col_q, col_d;
  logic [7:0]         row_q, row_d;
  logic               ovf_q, ovf_d;
  logic               eol, eof, sample, push, pop, full, empty;
  logic [ENTRY_W-1:0] entry, head;

  assign eol    = (col_q == COL_LAST);
  assign eof    = eol && (row_q == ROW_LAST);
  assign sample = stream.sum_done && (state_q == ST_RUN);
  assign pop    = stream.pix_valid && stream.pix_ready;
  // A full FIFO still takes the sample if the head leaves this same cycle.
  assign push   = sample && (!full || pop);
  assign entry  = {eof, eol, rectify(stream.sum_in)};

  result_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign stream.pix_valid = !empty;
  assign stream.pix_eof   = head[9];
  assign stream.pix_eol   = head[8];
  assign stream.pix_out   = head[7:0];

  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign frame_done = (state_q == ST_DONE);
  assign overflow   = ovf_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        col_d   = '0;
        row_d   = '0;
        ovf_d   = 1'b0;
      end
      ST_RUN: if (sample) begin
        // Dropped samples still advance the raster position.
        if (!push) ovf_d = 1'b1;
        if (eol) begin
          col_d = '0;
          row_d = eof ? 8'd0 : row_q + 8'd1;
        end else begin
          col_d = col_q + 8'd1;
        end
        if (eof) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_laplacian_result_collector.sv
// Bench for laplacian_result_collector: three instances (2x2, 26x26, 3x2
// frames, DEPTH 4) against a queue-based frame model, plus literal checks.
module tb_laplacian_result_collector;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start_a[NI];
  logic signed [5:0] sum_a[NI];
  logic              done_a[NI];
  logic              rdy_a[NI];
  logic [7:0]        po[NI];
  logic              peol[NI], peof[NI], pvld[NI];
  logic              busy_a[NI], fd_a[NI], ovf_a[NI];

  genvar g;
  for (g = 0; g < NI; g++) begin : g_inst
    laplacian_result_collector_if sif();
    assign sif.sum_in    = sum_a[g];
    assign sif.sum_done  = done_a[g];
    assign sif.pix_ready = rdy_a[g];
    assign po[g]   = sif.pix_out;
    assign peol[g] = sif.pix_eol;
    assign peof[g] = sif.pix_eof;
    assign pvld[g] = sif.pix_valid;
    laplacian_result_collector #(
      .OUT_W (g == 0 ? 2 : (g == 1 ? 26 : 3)),
      .OUT_H (g == 1 ? 26 : 2),
      .DEPTH (4)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_a[g]),
      .busy       (busy_a[g]),
      .frame_done (fd_a[g]),
      .overflow   (ovf_a[g]),
      .stream     (sif)
    );
  end

  int cmp_cnt = 0;
  int err_cnt = 0;

  function automatic int w_of(int i); return i == 0 ? 2 : (i == 1 ? 26 : 3); endfunction
  function automatic int h_of(int i); return i == 1 ? 26 : 2; endfunction
  function automatic int rect(int s); return s < 0 ? 0 : s * 8; endfunction

  // ---- behavioural model: phase + sample index + output queue ----
  localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DONE = 3;
  int         mph[NI];
  int         mn[NI];
  bit         movf[NI];
  logic [9:0] mq[NI][$];

  task automatic model_step(input int i);
    bit pop, pu;
    logic [9:0] ent;
    int last;
    pop  = (mq[i].size() > 0) && rdy_a[i];
    pu   = 1'b0;
    ent  = '0;
    last = w_of(i) * h_of(i) - 1;
    case (mph[i])
      P_IDLE: if (start_a[i]) begin mph[i] = P_RUN; mn[i] = 0; movf[i] = 1'b0; end
      P_RUN: if (done_a[i]) begin
        ent = {mn[i] == last, (mn[i] % w_of(i)) == w_of(i) - 1, 8'(rect(int'(sum_a[i])))};
        if (mq[i].size() < 4 || pop) pu = 1'b1; else movf[i] = 1'b1;
        if (mn[i] == last) mph[i] = P_FLUSH;
        mn[i]++;
      end
      P_FLUSH: if (mq[i].size() == 0) mph[i] = P_DONE;
      default: mph[i] = P_IDLE;
    endcase
    if (pop) void'(mq[i].pop_front());
    if (pu) mq[i].push_back(ent);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        mph[i] = P_IDLE; mn[i] = 0; movf[i] = 1'b0; mq[i].delete();
      end
    end else begin
      for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  // ---- per-cycle compare and capture ----
  logic [9:0] cap[NI][$];
  int         fd_cnt[NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [13:0] exp_v, got_v;
      logic [9:0]  hd;
      hd    = (mq[i].size() > 0) ? mq[i][0] : 10'd0;
      exp_v = {mq[i].size() > 0, hd, mph[i] == P_RUN || mph[i] == P_FLUSH,
               mph[i] == P_DONE, movf[i]};
      got_v = {pvld[i], peof[i], peol[i], po[i], busy_a[i], fd_a[i], ovf_a[i]};
      cmp_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++;
        $display("FAIL cycle_cmp inst%0d t=%0t got=%h expected=%h", i, $time, got_v, exp_v);
      end
      if (pvld[i] && rdy_a[i]) cap[i].push_back({peof[i], peol[i], po[i]});
      if (fd_a[i]) fd_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input int got, input int expv);
    cmp_cnt++;
    if (got != expv) begin
      err_cnt++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int i);
    start_a[i] = 1'b1; tick(); start_a[i] = 1'b0;
  endtask

  task automatic wait_fd(input int i, input int base, input int bound);
    int n = 0;
    while (fd_cnt[i] == base && n < bound) begin tick(); n++; end
    chk("frame_done_timeout", int'(fd_cnt[i] != base), 1);
  endtask

  task automatic send(input int i, input int s);
    done_a[i] = 1'b1; sum_a[i] = 6'(s); tick(); done_a[i] = 1'b0;
  endtask

  int fd0, bad, eolc, eofc, sent, cyc;
  int sv[6];
  int exp_e[$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 0; sum_a[i] = 0; done_a[i] = 0; rdy_a[i] = 0; fd_cnt[i] = 0;
    end
    repeat (3) tick();
    chk("reset_valid", int'(pvld[0] | pvld[1] | pvld[2]), 0);
    chk("reset_busy", int'(busy_a[0] | busy_a[1] | busy_a[2]), 0);
    rst_n = 1'b1;
    tick();

    // 2x2 frame, back-to-back samples, ready held high
    cap[0].delete(); fd0 = fd_cnt[0]; rdy_a[0] = 1'b1;
    pulse_start(0);
    chk("busy_after_start", int'(busy_a[0]), 1);
    done_a[0] = 1'b1;
    sum_a[0] = 6'sd5;   tick();
    sum_a[0] = -6'sd3;  tick();
    sum_a[0] = 6'sd31;  tick();
    sum_a[0] = -6'sd32; tick();
    done_a[0] = 1'b0;
    wait_fd(0, fd0, 30);
    repeat (3) tick();
    chk("a_count", cap[0].size(), 4);
    if (cap[0].size() == 4) begin
      chk("a_px0", int'(cap[0][0]), 'h028);
      chk("a_px1", int'(cap[0][1]), 'h100);
      chk("a_px2", int'(cap[0][2]), 'h0F8);
      chk("a_px3", int'(cap[0][3]), 'h300);
    end
    chk("a_fd_pulses", fd_cnt[0] - fd0, 1);
    chk("a_overflow", int'(ovf_a[0]), 0);

    // 3x2 frame, ready low: 4 stored, 2 dropped
    cap[2].delete(); fd0 = fd_cnt[2]; rdy_a[2] = 1'b0;
    pulse_start(2);
    for (int k = 0; k < 6; k++) begin
      sv[k] = int'($urandom_range(0, 63)) - 32;
      send(2, sv[k]);
    end
    repeat (2) tick();
    chk("b_overflow", int'(ovf_a[2]), 1);
    chk("b_valid_held", int'(pvld[2]), 1);
    rdy_a[2] = 1'b1;
    wait_fd(2, fd0, 30);
    chk("b_count", cap[2].size(), 4);
    for (int k = 0; k < 4 && k < cap[2].size(); k++)
      chk("b_px", int'(cap[2][k]), ((k == 2) ? 256 : 0) + rect(sv[k]));
    chk("b_overflow_sticky", int'(ovf_a[2]), 1);

    // full FIFO with simultaneous pop and push: nothing dropped
    cap[2].delete(); fd0 = fd_cnt[2]; rdy_a[2] = 1'b0;
    pulse_start(2);
    chk("c_overflow_cleared", int'(ovf_a[2]), 0);
    for (int k = 0; k < 4; k++) send(2, k + 1);
    rdy_a[2] = 1'b1;
    send(2, 5);
    chk("c_overflow_after_full_push", int'(ovf_a[2]), 0);
    send(2, 6);
    wait_fd(2, fd0, 30);
    chk("c_count", cap[2].size(), 6);
    chk("c_overflow", int'(ovf_a[2]), 0);
    if (cap[2].size() == 6) chk("c_last", int'(cap[2][5]), 'h330);

    // sum_done outside RUN and start during RUN are ignored
    cap[0].delete(); fd0 = fd_cnt[0]; rdy_a[0] = 1'b1;
    done_a[0] = 1'b1;
    repeat (3) begin sum_a[0] = 6'($urandom); tick(); end
    done_a[0] = 1'b0;
    chk("d_idle_no_write", int'(pvld[0]), 0);
    chk("d_idle_busy", int'(busy_a[0]), 0);
    pulse_start(0);
    send(0, 7);
    tick();
    start_a[0] = 1'b1; send(0, 9); start_a[0] = 1'b0;
    send(0, 1);
    done_a[0] = 1'b1; sum_a[0] = 6'sd2; tick();
    repeat (8) begin sum_a[0] = 6'($urandom); tick(); end
    done_a[0] = 1'b0;
    if (fd_cnt[0] == fd0) wait_fd(0, fd0, 30);
    repeat (4) tick();
    chk("d_count", cap[0].size(), 4);
    chk("d_fd_pulses", fd_cnt[0] - fd0, 1);
    if (cap[0].size() == 4) chk("d_last", int'(cap[0][3]), 'h310);

    // full 26x26 frame, random ready
    cap[1].delete(); fd0 = fd_cnt[1]; exp_e.delete(); sent = 0; cyc = 0;
    pulse_start(1);
    while (sent < 676 && cyc < 20000) begin
      rdy_a[1] = 1'($urandom_range(0, 1));
      done_a[1] = 1'b0;
      if (mq[1].size() < 4 && $urandom_range(0, 1) == 1) begin
        done_a[1] = 1'b1;
        sum_a[1] = 6'($urandom);
        exp_e.push_back(((sent == 675) ? 512 : 0) + ((sent % 26 == 25) ? 256 : 0)
                        + rect(int'(sum_a[1])));
        sent++;
      end
      tick(); cyc++;
    end
    done_a[1] = 1'b0; rdy_a[1] = 1'b1;
    chk("e_all_sent", sent, 676);
    wait_fd(1, fd0, 100);
    chk("e_count", cap[1].size(), 676);
    bad = 0; eolc = 0; eofc = 0;
    for (int k = 0; k < cap[1].size(); k++) begin
      if (k >= exp_e.size() || int'(cap[1][k]) != exp_e[k]) bad++;
      if (cap[1][k][8]) eolc++;
      if (cap[1][k][9]) eofc++;
    end
    chk("e_raster_order", bad, 0);
    chk("e_eol_count", eolc, 26);
    chk("e_eof_count", eofc, 1);
    chk("e_overflow", int'(ovf_a[1]), 0);

    // async reset mid-RUN with 3 entries queued
    fd0 = fd_cnt[1]; rdy_a[1] = 1'b0;
    pulse_start(1);
    for (int k = 0; k < 3; k++) send(1, 10 + k);
    chk("f_valid_before_reset", int'(pvld[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_outputs_in_reset", int'({pvld[1], peol[1], peof[1], po[1], busy_a[1], fd_a[1], ovf_a[1]}), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("f_idle_busy", int'(busy_a[1]), 0);
    chk("f_idle_valid", int'(pvld[1]), 0);
    chk("f_no_frame_done", fd_cnt[1] - fd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
